// File: rtl/prod_accum_if.sv
// Product handshake between the sequential multiplier (master) and the
// dot-product accumulator (slave).
interface prod_accum_if #(
    parameter int unsigned WIDTH = 8
);
    logic signed [2*WIDTH-1:0] p;
    logic                      p_rdy;
    logic                      mult_restart;

    modport slave (
        input  p,
        input  p_rdy,
        output mult_restart
    );

    modport master (
        output p,
        output p_rdy,
        input  mult_restart
    );
endinterface

// File: rtl/prod_accum.sv
// Collects NTERMS signed products from the multiplier one at a time and
// accumulates them into a saturating signed dot-product result.
module prod_accum #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ACCW   = 24,
    parameter int unsigned NTERMS = 4,
    parameter int unsigned CTRW   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    prod_accum_if.slave            mul,
    output logic signed [ACCW-1:0] acc,
    output logic                   acc_valid,
    output logic                   sat,
    output logic                   busy
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic [CTRW-1:0] LAST    = CTRW'(NTERMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_ADD,
        S_DONE
    } state_t;

    state_t                 state, state_next;
    logic signed [ACCW-1:0] acc_next;
    logic                   sat_next;
    logic [CTRW-1:0]        ctr, ctr_next, ctr_inc;
    logic                   p_rdy_q, p_rdy_q_next;
    logic [PW-1:0]          p_q, p_q_next;

    logic signed [ACCW-1:0] p_ext;
    logic signed [ACCW-1:0] sum_raw;
    logic signed [ACCW-1:0] sum_sat;
    logic                   ovf;

    // Saturating add of the latched product into the running sum
    always_comb begin
        p_ext   = {{(ACCW-PW){p_q[PW-1]}}, p_q};
        sum_raw = acc + p_ext;
        ovf     = (acc[ACCW-1] == p_ext[ACCW-1]) && (sum_raw[ACCW-1] != acc[ACCW-1]);
        if (ovf) begin
            sum_sat = acc[ACCW-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_raw;
        end
        ctr_inc = ctr + CTRW'(1);
    end

    // Next-state and datapath update
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        sat_next     = sat;
        ctr_next     = ctr;
        p_rdy_q_next = p_rdy_q;
        p_q_next     = p_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_ARM;
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    ctr_next   = '0;
                end
            end
            S_ARM: begin
                // A fresh rising edge of p_rdy is required after every restart
                p_rdy_q_next = 1'b0;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                p_rdy_q_next = mul.p_rdy;
                if (mul.p_rdy && !p_rdy_q) begin
                    p_q_next   = mul.p;
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                acc_next   = sum_sat;
                sat_next   = sat | ovf;
                ctr_next   = ctr_inc;
                state_next = (ctr_inc == LAST) ? S_DONE : S_ARM;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            acc              <= '0;
            sat              <= 1'b0;
            ctr              <= '0;
            p_rdy_q          <= 1'b0;
            p_q              <= '0;
            mul.mult_restart <= 1'b0;
            acc_valid        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            acc              <= acc_next;
            sat              <= sat_next;
            ctr              <= ctr_next;
            p_rdy_q          <= p_rdy_q_next;
            p_q              <= p_q_next;
            mul.mult_restart <= (state_next == S_ARM);
            acc_valid        <= (state_next == S_DONE);
            busy             <= (state_next == S_ARM) || (state_next == S_WAIT) ||
                                (state_next == S_ADD);
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum: directed vector table, hand-written reset/start
// sequences and random runs against a saturating-sum model, on ACCW=24 and ACCW=17.
module tb_prod_accum;
    logic clk = 1'b0;
    logic reset;
    logic start;

    logic signed [15:0] p_drv;
    logic               p_rdy_drv;

    logic signed [23:0] acc24;
    logic               av24, sat24, busy24;
    logic signed [16:0] acc17;
    logic               av17, sat17, busy17;

    prod_accum_if #(.WIDTH(8)) mif ();
    prod_accum_if #(.WIDTH(8)) mif17 ();

    assign mif.p       = p_drv;
    assign mif.p_rdy   = p_rdy_drv;
    assign mif17.p     = p_drv;
    assign mif17.p_rdy = p_rdy_drv;

    prod_accum #(.WIDTH(8), .ACCW(24), .NTERMS(4), .CTRW(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mul(mif),
        .acc(acc24), .acc_valid(av24), .sat(sat24), .busy(busy24));

    prod_accum #(.WIDTH(8), .ACCW(17), .NTERMS(4), .CTRW(3)) u_dut17 (
        .clk(clk), .reset(reset), .start(start), .mul(mif17),
        .acc(acc17), .acc_valid(av17), .sat(sat17), .busy(busy17));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Multiplier stand-in: drops p_rdy on restart, raises it with the next product after lat cycles
    int prod_q [4];
    int lat_cur  = 1;
    int idx      = 0;
    int cnt      = 0;
    bit pend     = 1'b0;
    int pulses   = 0;
    bit prev_mr  = 1'b0;
    bit b2b      = 1'b0;
    bit mr_diff  = 1'b0;

    always @(negedge clk) begin
        if (mif.mult_restart !== mif17.mult_restart) mr_diff = 1'b1;
        if (mif.mult_restart && prev_mr) b2b = 1'b1;
        prev_mr = mif.mult_restart;
        if (reset) begin
            p_rdy_drv = 1'b0;
            pend      = 1'b0;
        end else if (mif.mult_restart) begin
            pulses++;
            p_rdy_drv = 1'b0;
            pend      = 1'b1;
            cnt       = lat_cur;
        end else if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                p_drv     = (idx < 4) ? 16'(prod_q[idx]) : 16'sd0;
                idx++;
                p_rdy_drv = 1'b1;
                pend      = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: sum term by term, clamping to the accumulator range after each add
    task automatic model(input int pr[4], input int accw, output longint res, output longint s);
        longint mx, mn;
        mx  = (longint'(1) <<< (accw - 1)) - 1;
        mn  = -mx - 1;
        res = 0;
        s   = 0;
        for (int i = 0; i < 4; i++) begin
            res = res + longint'(pr[i]);
            if (res > mx) begin res = mx; s = 1; end
            else if (res < mn) begin res = mn; s = 1; end
        end
    endtask

    typedef struct {
        int     p0, p1, p2, p3;
        int     lat;
        bit     inj;
        longint e24, s24, e17, s17;
    } vec_t;

    task automatic start_run(input int p0, input int p1, input int p2, input int p3, input int lat);
        prod_q[0] = p0; prod_q[1] = p1; prod_q[2] = p2; prod_q[3] = p3;
        lat_cur = lat;
        idx     = 0;
        pulses  = 0;
        b2b     = 1'b0;
        mr_diff = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("start_clear_acc", acc24, 0);
        check("start_clear_sat", sat24, 0);
        check("start_busy", busy24, 1);
        check("start_valid_low", av24, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit done = 1'b0;
        bit injected = 1'b0;
        start_run(v.p0, v.p1, v.p2, v.p3, v.lat);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (av24) begin done = 1'b1; break; end
            if (v.inj && !injected && i > 1 && busy24 && !mif.mult_restart && !p_rdy_drv) begin
                start    = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_reached", done, 1);
        check("acc24", acc24, v.e24);
        check("sat24", sat24, v.s24);
        check("acc17", acc17, v.e17);
        check("sat17", sat17, v.s17);
        check("valid17", av17, 1);
        check("restart_pulses", pulses, 4);
        check("restart_b2b", b2b, 0);
        check("restart_match", mr_diff, 0);
        check("done_not_busy", busy24, 0);
        repeat (3) @(negedge clk);
        check("done_hold_acc", acc24, v.e24);
        check("done_hold_valid", av24, 1);
        check("done_no_restart", pulses, 4);
    endtask

    vec_t tbl [7];

    initial begin
        int     pr [4];
        vec_t   v;
        longint e, s;
        bit     hit;

        tbl[0] = '{3, 5, -2, 10, 2, 1'b0, 16, 0, 16, 0};
        tbl[1] = '{16384, 16384, 16384, 16384, 20, 1'b0, 65536, 0, 65535, 1};
        tbl[2] = '{32767, 32767, 32767, 32767, 1, 1'b0, 131068, 0, 65535, 1};
        tbl[3] = '{3, 5, -2, 10, 3, 1'b1, 16, 0, 16, 0};
        tbl[4] = '{1, 1, 1, 1, 1, 1'b0, 4, 0, 4, 0};
        tbl[5] = '{-32768, -32768, -32768, -32768, 2, 1'b0, -131072, 0, -65536, 1};
        tbl[6] = '{32767, 32767, 32767, -32768, 4, 1'b0, 65533, 0, 32767, 1};

        reset     = 1'b1;
        start     = 1'b0;
        p_drv     = '0;
        p_rdy_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc", acc24, 0);
        check("rst_valid", av24, 0);
        check("rst_sat", sat24, 0);
        check("rst_busy", busy24, 0);
        check("rst_restart", mif.mult_restart, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_restart", pulses, 0);

        foreach (tbl[k]) run_vec(tbl[k]);

        // Reset while the second term is being added
        start_run(3, 5, -2, 10, 3);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (idx == 2) begin hit = 1'b1; break; end
        end
        check("midadd_reached", hit, 1);
        @(negedge clk);
        check("midadd_acc_before", acc24, 3);
        reset = 1'b1;
        @(negedge clk);
        check("midadd_rst_acc", acc24, 0);
        check("midadd_rst_busy", busy24, 0);
        check("midadd_rst_valid", av24, 0);
        check("midadd_rst_restart", mif.mult_restart, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", busy24, 0);

        v = '{1, 1, 1, 1, 2, 1'b0, 4, 0, 4, 0};
        run_vec(v);

        // Random runs against the model
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (r % 2 == 0)
                    pr[i] = (int'($urandom_range(0, 255)) - 128) * (int'($urandom_range(0, 255)) - 128);
                else
                    pr[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            v.p0 = pr[0]; v.p1 = pr[1]; v.p2 = pr[2]; v.p3 = pr[3];
            v.lat = int'($urandom_range(1, 6));
            v.inj = (r % 3 == 0);
            model(pr, 24, e, s); v.e24 = e; v.s24 = s;
            model(pr, 17, e, s); v.e17 = e; v.s17 = s;
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
